// File: rtl/out_mem_pkg.sv
// Shared types for the output frame buffer: FSM states and pixel packing modes.
package out_mem_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DONE  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        PACK_SINGLE = 1'b0,
        PACK_LANES  = 1'b1
    } pack_mode_e;

endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry register skid between the RAM read port and the drain stream.
// Upstream only pushes when a slot is guaranteed free, so a push into a full,
// stalled buffer never happens.
module frame_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] ent0_data_reg, ent1_data_reg;
    logic              ent0_last_reg, ent1_last_reg;
    logic [1:0]        count_reg, count_next;
    logic              push, pop;

    assign push      = in_valid;
    assign pop       = (count_reg != 2'd0) && out_ready;
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = ent0_data_reg;
    assign out_last  = ent0_last_reg;
    assign count     = count_reg;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Entry 0 is the head presented on out_*; it only changes on a pop or when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_data_reg <= '0;
            ent0_last_reg <= 1'b0;
            ent1_data_reg <= '0;
            ent1_last_reg <= 1'b0;
            count_reg     <= 2'd0;
        end else if (flush) begin
            count_reg <= 2'd0;
        end else begin
            count_reg <= count_next;
            if (pop) begin
                if (count_reg == 2'd2) begin
                    ent0_data_reg <= ent1_data_reg;
                    ent0_last_reg <= ent1_last_reg;
                    if (push) begin
                        ent1_data_reg <= in_data;
                        ent1_last_reg <= in_last;
                    end
                end else if (push) begin
                    ent0_data_reg <= in_data;
                    ent0_last_reg <= in_last;
                end
            end else if (push) begin
                if (count_reg == 2'd0) begin
                    ent0_data_reg <= in_data;
                    ent0_last_reg <= in_last;
                end else begin
                    ent1_data_reg <= in_data;
                    ent1_last_reg <= in_last;
                end
            end
        end
    end

endmodule

// File: rtl/out_frame_buffer.sv
// Output frame buffer: fills a frame from the result bus (single or packed
// pixels), then streams it out in order through a skid buffer.
module out_frame_buffer
    import out_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IN_W   = 32,
    parameter int DEPTH  = 51200,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_clear,
    input  logic              pack_mode,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IN_W-1:0]   wr_data,
    input  logic              drain_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic [CNT_W-1:0]  pix_count,
    output logic              busy
);

    localparam int LANES = IN_W / DATA_W;
    localparam int WORDS = DEPTH / LANES;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    state_e            state_reg;
    pack_mode_e        mode_reg, eff_mode;
    logic [CNT_W-1:0]  pix_count_reg, pix_sum, inc;
    logic [CNT_W-1:0]  rd_ptr_reg;
    logic              frame_done_reg;
    logic              rd_valid_reg, rd_last_reg;
    logic [LW-1:0]     rd_lane_reg;
    logic              accept, rd_en, rd_room;
    logic [AW-1:0]     wr_word, rd_word;
    logic [LW-1:0]     wr_lane, rd_lane;
    logic [DATA_W-1:0] rd_q [LANES];
    logic [1:0]        skid_count;
    logic              skid_pop;
    logic [2:0]        occ;

    assign wr_ready   = (state_reg == FILL);
    assign busy       = (state_reg == DRAIN);
    assign frame_done = frame_done_reg;
    assign pix_count  = pix_count_reg;

    // The packing mode is taken from the input on a frame's first write, then from the latch.
    assign eff_mode = (pix_count_reg == '0) ? pack_mode_e'(pack_mode) : mode_reg;
    assign inc      = (eff_mode == PACK_LANES) ? CNT_W'(LANES) : CNT_W'(1);
    assign pix_sum  = pix_count_reg + inc;
    assign accept   = wr_valid && (state_reg == FILL) && !frame_clear;
    assign wr_word  = AW'(pix_count_reg / CNT_W'(LANES));
    assign wr_lane  = LW'(pix_count_reg % CNT_W'(LANES));
    assign rd_word  = AW'(rd_ptr_reg / CNT_W'(LANES));
    assign rd_lane  = LW'(rd_ptr_reg % CNT_W'(LANES));

    // Issue a read only if the skid will still have a free slot when the data lands.
    assign skid_pop = out_valid && out_ready;
    assign occ      = {1'b0, skid_count} + {2'b00, rd_valid_reg};
    assign rd_room  = occ < (3'd2 + {2'b00, skid_pop});
    assign rd_en    = (state_reg == DRAIN) && (rd_ptr_reg < CNT_W'(DEPTH)) && rd_room && !frame_clear;

    // One RAM bank per lane so a packed write lands in all lanes of one word at once.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] mem [WORDS];
            logic              lane_we;
            logic [DATA_W-1:0] lane_wdata;

            assign lane_we    = accept && ((eff_mode == PACK_LANES) || (wr_lane == LW'(gi)));
            assign lane_wdata = (eff_mode == PACK_LANES) ? wr_data[gi*DATA_W +: DATA_W]
                                                          : wr_data[DATA_W-1:0];

            // Simple dual-port bank: byte-lane write, registered read.
            always_ff @(posedge clk) begin
                if (lane_we) begin
                    mem[wr_word] <= lane_wdata;
                end
                if (rd_en) begin
                    rd_q[gi] <= mem[rd_word];
                end
            end
        end
    endgenerate

    // Frame FSM plus read pointer and read-pipeline tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FILL;
            mode_reg       <= PACK_SINGLE;
            pix_count_reg  <= '0;
            rd_ptr_reg     <= '0;
            frame_done_reg <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            rd_lane_reg    <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            rd_valid_reg   <= rd_en;
            if (rd_en) begin
                rd_ptr_reg  <= rd_ptr_reg + CNT_W'(1);
                rd_last_reg <= (rd_ptr_reg == CNT_W'(DEPTH - 1));
                rd_lane_reg <= rd_lane;
            end
            if (frame_clear) begin
                state_reg     <= FILL;
                pix_count_reg <= '0;
                rd_ptr_reg    <= '0;
                rd_valid_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    FILL: begin
                        if (accept) begin
                            pix_count_reg <= pix_sum;
                            if (pix_count_reg == '0) begin
                                mode_reg <= pack_mode_e'(pack_mode);
                            end
                            if (pix_sum == CNT_W'(DEPTH)) begin
                                state_reg      <= DONE;
                                frame_done_reg <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (drain_start) begin
                            state_reg  <= DRAIN;
                            rd_ptr_reg <= '0;
                        end
                    end
                    DRAIN: begin
                        if (skid_pop && out_last) begin
                            state_reg     <= FILL;
                            pix_count_reg <= '0;
                        end
                    end
                    default: state_reg <= FILL;
                endcase
            end
        end
    end

    frame_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (frame_clear),
        .in_valid  (rd_valid_reg),
        .in_data   (rd_q[rd_lane_reg]),
        .in_last   (rd_last_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_out_frame_buffer.sv
// Self-checking bench for out_frame_buffer with an 8-pixel frame and 4 lanes.
module tb_out_frame_buffer;

    localparam int DATA_W = 8;
    localparam int IN_W   = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_clear;
    logic              pack_mode;
    logic              wr_valid;
    logic              wr_ready;
    logic [IN_W-1:0]   wr_data;
    logic              drain_start;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              frame_done;
    logic [CNT_W-1:0]  pix_count;
    logic              busy;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    out_frame_buffer #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_clear (frame_clear),
        .pack_mode   (pack_mode),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .drain_start (drain_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .pix_count   (pix_count),
        .busy        (busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One accepted write; eff says whether the frame is packed, for the scoreboard.
    task automatic write_word(input logic mode, input logic eff, input logic [IN_W-1:0] d);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready_before_write: got %b expected 1", wr_ready);
        end
        pack_mode = mode;
        wr_valid  = 1'b1;
        wr_data   = d;
        if (eff) begin
            for (int l = 0; l < IN_W / DATA_W; l++) exp_q.push_back(d[l*DATA_W +: DATA_W]);
        end else begin
            exp_q.push_back(d[DATA_W-1:0]);
        end
        $display("write mode=%0b data=%08h", mode, d);
        cyc();
        wr_valid = 1'b0;
    endtask

    // Fill a mode-0 frame with base, base+1, ...
    task automatic fill_single(input logic [DATA_W-1:0] base);
        for (int i = 0; i < DEPTH; i++) write_word(1'b0, 1'b0, {24'hA5A5A5, base + DATA_W'(i)});
    endtask

    // Start a drain and consume the whole frame; stall_pat=1 toggles out_ready 1,0,0,1.
    task automatic drain_frame(input logic stall_pat);
        logic [3:0]        pat;
        logic              held;
        logic [DATA_W-1:0] held_data;
        logic              held_last;
        logic [DATA_W-1:0] e;
        int                n;
        pat  = 4'b1001;
        held = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        n = 0;
        out_ready   = 1'b1;
        drain_start = 1'b1;
        cyc();
        drain_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b expected 1", busy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_lat1: got %b expected 0", out_valid); end
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_lat2: got %b expected 0", out_valid); end
        cyc();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_first_valid: got %b expected 1", out_valid); end
        while (exp_q.size() > 0 && n < 200) begin
            out_ready = stall_pat ? pat[n % 4] : 1'b1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b d=%02h l=%b expected v=1 d=%02h l=%b",
                             out_valid, out_data, out_last, held_data, held_last);
                end
            end
            if (!stall_pat) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL no_bubble: got %b expected 1", out_valid); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                e = exp_q.pop_front();
                $display("xfer data=%02h last=%b", out_data, out_last);
                checks++;
                if (out_data !== e) begin errors++; $display("FAIL drain_data: got %02h expected %02h", out_data, e); end
                checks++;
                if (out_last !== (exp_q.size() == 0)) begin
                    errors++;
                    $display("FAIL drain_last: got %b expected %b", out_last, exp_q.size() == 0);
                end
                held = 1'b0;
            end else if (out_valid === 1'b1) begin
                held      = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end
            cyc();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pixels left expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (wr_ready !== 1'b1 || pix_count !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got rdy=%b cnt=%0d busy=%b v=%b expected 1 0 0 0",
                     wr_ready, pix_count, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_clear = 1'b0; pack_mode = 1'b0; wr_valid = 1'b0;
        wr_data = '0; drain_start = 1'b0; out_ready = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b expected 1", wr_ready); end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_out: got v=%b d=%02h l=%b expected 0 00 0", out_valid, out_data, out_last);
        end
        checks++;
        if (frame_done !== 1'b0 || pix_count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_status: got fd=%b cnt=%0d busy=%b expected 0 0 0", frame_done, pix_count, busy);
        end
    endtask

    task automatic test_fill_single();
        for (int i = 0; i < DEPTH; i++) begin
            write_word(1'b0, 1'b0, {24'hA5A5A5, 8'h11 + 8'(i)});
            checks++;
            if (pix_count !== CNT_W'(i + 1)) begin
                errors++; $display("FAIL single_count: got %0d expected %0d", pix_count, i + 1);
            end
            checks++;
            if (frame_done !== (i == DEPTH - 1)) begin
                errors++; $display("FAIL single_done: got %b expected %b", frame_done, i == DEPTH - 1);
            end
        end
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL single_wr_ready: got %b expected 0", wr_ready); end
        cyc();
        checks++;
        if (frame_done !== 1'b0 || pix_count !== 4'd8) begin
            errors++; $display("FAIL single_pulse: got fd=%b cnt=%0d expected 0 8", frame_done, pix_count);
        end
        drain_frame(1'b0);
    endtask

    task automatic test_fill_packed();
        write_word(1'b1, 1'b1, 32'h44332211);
        checks++;
        if (pix_count !== 4'd4 || frame_done !== 1'b0) begin
            errors++; $display("FAIL packed_first: got cnt=%0d fd=%b expected 4 0", pix_count, frame_done);
        end
        write_word(1'b1, 1'b1, 32'h88776655);
        checks++;
        if (frame_done !== 1'b1 || wr_ready !== 1'b0) begin
            errors++; $display("FAIL packed_done: got fd=%b rdy=%b expected 1 0", frame_done, wr_ready);
        end
        for (int i = 0; i < 5; i++) cyc();
        checks++;
        if (wr_ready !== 1'b0 || out_valid !== 1'b0 || pix_count !== 4'd8) begin
            errors++;
            $display("FAIL done_hold: got rdy=%b v=%b cnt=%0d expected 0 0 8", wr_ready, out_valid, pix_count);
        end
        drain_frame(1'b1);
    endtask

    task automatic test_clear();
        drain_start = 1'b1;
        cyc();
        drain_start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drain_in_fill: got %b expected 0", busy); end
        for (int i = 0; i < 5; i++) write_word(1'b0, 1'b0, {24'h0, 8'h51 + 8'(i)});
        checks++;
        if (pix_count !== 4'd5) begin errors++; $display("FAIL clr_pre: got %0d expected 5", pix_count); end
        frame_clear = 1'b1; wr_valid = 1'b1; wr_data = 32'h000000EE;
        cyc();
        frame_clear = 1'b0; wr_valid = 1'b0;
        exp_q.delete();
        checks++;
        if (pix_count !== 4'd0 || frame_done !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_post: got cnt=%0d fd=%b rdy=%b expected 0 0 1", pix_count, frame_done, wr_ready);
        end
        fill_single(8'h61);
        drain_frame(1'b0);
    endtask

    task automatic test_mode_flip();
        write_word(1'b1, 1'b1, 32'hDDCCBBAA);
        write_word(1'b0, 1'b1, 32'h44332211);
        checks++;
        if (frame_done !== 1'b1 || pix_count !== 4'd8) begin
            errors++; $display("FAIL flip_done: got fd=%b cnt=%0d expected 1 8", frame_done, pix_count);
        end
        drain_frame(1'b0);
    endtask

    task automatic test_reset_mid_drain();
        fill_single(8'h71);
        out_ready   = 1'b1;
        drain_start = 1'b1;
        cyc();
        drain_start = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL rstd_xfer: got v=%b d=%02h expected 1 %02h", out_valid, out_data, exp_q[0]);
            end
            $display("xfer data=%02h last=%b", out_data, out_last);
            void'(exp_q.pop_front());
            cyc();
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rstd_async: got v=%b d=%02h busy=%b l=%b expected 0 00 0 0",
                     out_valid, out_data, busy, out_last);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        cyc();
        checks++;
        if (wr_ready !== 1'b1 || pix_count !== 4'd0) begin
            errors++; $display("FAIL rstd_release: got rdy=%b cnt=%0d expected 1 0", wr_ready, pix_count);
        end
    endtask

    task automatic test_back_to_back();
        write_word(1'b1, 1'b1, 32'hF4F3F2F1);
        write_word(1'b1, 1'b1, 32'hF8F7F6F5);
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", frame_done); end
        drain_frame(1'b1);
    endtask

    initial begin
        test_reset();
        test_fill_single();
        test_fill_packed();
        test_clear();
        test_mode_flip();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
